jtdsp16_pio_host: RTL and testbench
===================================

# jtdsp16_pio_host

Host-side responder for the jtdsp16 parallel I/O port. It answers the DSP's `pods_n`/`pids_n` strobes with two word FIFOs: DSP→host, captured on each output strobe, and host→DSP, presented on `pbus_in` and popped on each input strobe. A status word is readable through `psel`, and the DSP can be interrupted when host data arrives. It sits beside `jtdsp16` in system tops and replaces the ad-hoc parallel-port stimulus used in simulation benches.

## Interface
- `AW`, default 4: FIFO address width. Depth is 2^AW words. Legal range is 1..4.
- `clk` in 1: system clock, the same clock as `jtdsp16`.
- `rst` in 1: synchronous reset, active-high.
- `pbus_out` in 16: DSP parallel output data.
- `pods_n` in 1: DSP output data strobe, active low. Data is taken at the rising edge.
- `pids_n` in 1: DSP input data strobe, active low. The pop happens at the rising edge.
- `psel` in 1: peripheral select. 0 selects the data FIFOs; 1 selects status/control.
- `pbus_in` out 16: data presented to the DSP.
- `irq` out 1: interrupt request to the DSP.
- `iack` in 1: interrupt acknowledge from the DSP.
- `host_din` in 16: host write data.
- `host_wr` in 1: host write strobe, one word per cycle high.
- `host_full` out 1: the host→DSP FIFO is full.
- `host_dout` out 16: head of the DSP→host FIFO.
- `host_rd` in 1: pop the DSP→host FIFO.
- `host_empty` out 1: the DSP→host FIFO is empty.

## Operation
- **Strobe sampling.** `pods_n` and `pids_n` are registered once per `clk` into `last_pods_n` and `last_pids_n`. An edge event is `strobe && !last_strobe`, i.e. a rising edge. The `psel` and `pbus_out` values sampled in that same cycle are the ones used.
- **DSP write, `psel`=0.** `pbus_out` is pushed into the d2h FIFO.
  - If the FIFO is full, the word is dropped and sticky `ovf` is set.
- **DSP write, `psel`=1.** Control word:
  - bit0=1 flushes both FIFOs.
  - bit1=1 clears `ovf` and `unf`.
  - All other bits are ignored.
- **DSP read, `psel`=0.** `pbus_in` shows the h2d head whenever `psel`=0; it is combinational from the FIFO head.
  - At the `pids_n` rising edge the head is popped.
  - If the FIFO is empty, `pbus_in`=16'h0000, no pop occurs and sticky `unf` is set.
- **DSP read, `psel`=1.** `pbus_in` = {`ovf`, `unf`, 4'b0, d2h_count[4:0], h2d_count[4:0]}. Counts are zero-extended. A pop never happens on a status read.
- **Host side.**
  - `host_wr` with `host_full`=0 pushes `host_din` into h2d. A write while full is ignored and no flag is set.
  - `host_rd` with `host_empty`=0 pops d2h. A read while empty is ignored.
- **Simultaneous events.**
  - A push and a pop on the same FIFO in one cycle both occur and the count is unchanged.
  - Exception: a push while the FIFO is full is rejected even if a pop happens that cycle.
  - A flush control word in the same cycle as a host push wins; the FIFO ends empty.
- **Pointers and counts.** Pointers are AW bits and wrap modulo 2^AW. Counts are AW+1 bits, range 0..2^AW.
- **IRQ.**
  - `irq` is set in the cycle after h2d goes from empty to non-empty.
  - `irq` is cleared when `iack`=1. Clear has priority over a set in the same cycle.
  - `irq` stays low on later pushes until the FIFO empties again.

## Timing
- Reset values: `pbus_in`=16'h0000 (h2d is empty), `irq`=0, `host_full`=0, `host_empty`=1, `host_dout`=16'h0000, flags cleared, pointers and counts 0. All `last_*` registers reset to 1.
- Strobe latency: a strobe rising edge at clk edge N is detected at N+1, and the FIFO and flags update at N+1.
  - Therefore `pods_n` and `pids_n` must each stay high for at least 1 clk and low for at least 1 clk.
  - `pbus_out` must be stable across the rising edge of `pods_n`.
- Host-side latency:
  - `host_dout` is combinational from the FIFO head.
  - `host_full` and `host_empty` update in the cycle after the push or pop.
  - A host write is visible on `pbus_in` one cycle later.
- Reset mid-operation: synchronous reset discards all queued data and pending `irq`. A strobe that is low at reset is not counted as an edge when it rises, because `last_*` is 1.

## Configuration
- `JTDSP16_PIO_IRQ_EN`:
  - When defined, the IRQ logic above is built.
  - When undefined, `irq` is tied to 0, `iack` is ignored, and no IRQ flop is built. FIFO behaviour is unchanged.

## Test plan
- Reset, then the DSP performs 3 `pods_n` pulses with `psel`=0 carrying 16'hbeef, 16'hbef0, 16'hbef1 → `host_empty` drops, and 3 `host_rd` return those words in order; `host_empty`=1 afterwards.
- Host writes 16'hcafe with `JTDSP16_PIO_IRQ_EN` defined → `irq`=1 one cycle later. `iack` clears it. A `pids_n` pulse with `psel`=0 reads 16'hcafe, and the h2d count returns to 0.
- With AW=2, the DSP writes 5 words → the 5th is dropped. A status read gives bit15=1 and d2h_count=4. Control word 16'h0002 clears `ovf`.
- A `pids_n` read with h2d empty → `pbus_in`=16'h0000 and `unf`=1. Status reads 16'h4000 while both FIFOs are empty.
- Host push and DSP pop in the same cycle with 2 words queued → count stays 2 and order is preserved. Control word 16'h0001 → both counts are 0 and `host_empty`=1.
- Assert `rst` while `pods_n` is low, then release → no spurious push, and all outputs are at their reset values.

Source files
------------

// File: rtl/jtdsp16_pio_host.sv
// jtdsp16_pio_fifo: generic word FIFO with synchronous flush and occupancy count.
// Latency: push visible at dout/count one clk later; dout is combinational from the head (0 when empty).
// Backpressure: a push while full and a pop while empty are dropped, even if the opposite operation happens that cycle.
module jtdsp16_pio_fifo #(
    parameter int AW = 4,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointers wrap modulo depth; flush empties the FIFO and overrides a push.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// jtdsp16_pio_host: host responder for the jtdsp16 parallel port (d2h and h2d FIFOs, status, irq).
// Latency: strobe rising edges act one clk after they happen; pbus_in/host_dout are combinational from FIFO heads.
// Backpressure: DSP writes into a full d2h are dropped (sticky ovf); host writes into a full h2d are ignored.
// Optional: define JTDSP16_PIO_IRQ_EN to build the host-data-arrived interrupt; otherwise irq is tied low.
module jtdsp16_pio_host #(
    parameter int AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pbus_out,
    input  logic        pods_n,
    input  logic        pids_n,
    input  logic        psel,
    output logic [15:0] pbus_in,
    output logic        irq,
    input  logic        iack,
    input  logic [15:0] host_din,
    input  logic        host_wr,
    output logic        host_full,
    output logic [15:0] host_dout,
    input  logic        host_rd,
    output logic        host_empty
);
    logic          last_pods_n;
    logic          last_pids_n;
    logic          pods_rise;
    logic          pids_rise;
    logic          ovf;
    logic          unf;
    logic          flush;
    logic          d2h_push;
    logic          h2d_pop;
    logic [15:0]   h2d_dout;
    logic [AW:0]   h2d_count;
    logic [AW:0]   d2h_count;
    logic          h2d_full;
    logic          h2d_empty;
    logic          d2h_full;
    logic [15:0]   status;

    assign pods_rise = pods_n && !last_pods_n;
    assign pids_rise = pids_n && !last_pids_n;
    assign d2h_push  = pods_rise && !psel;
    assign h2d_pop   = pids_rise && !psel;
    assign flush     = pods_rise && psel && pbus_out[0];
    assign status    = {ovf, unf, 4'b0, 5'(d2h_count), 5'(h2d_count)};
    assign host_full = h2d_full;

    // Strobe history; reset high so a strobe held low through reset never counts as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_pods_n <= 1'b1;
            last_pids_n <= 1'b1;
        end else begin
            last_pods_n <= pods_n;
            last_pids_n <= pids_n;
        end
    end

    // Sticky error flags: cleared by control bit1, set by a dropped write or an empty read.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (pods_rise && psel && pbus_out[1]) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end
            if (d2h_push && d2h_full)  ovf <= 1'b1;
            if (h2d_pop  && h2d_empty) unf <= 1'b1;
        end
    end

    // Data seen by the DSP: status word or the h2d head (already 0 when empty).
    always_comb begin
        pbus_in = h2d_dout;
        if (psel) pbus_in = status;
    end

    jtdsp16_pio_fifo #(.AW(AW), .DW(16)) u_d2h (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (d2h_push),
        .din   (pbus_out),
        .pop   (host_rd),
        .dout  (host_dout),
        .count (d2h_count),
        .full  (d2h_full),
        .empty (host_empty)
    );

    jtdsp16_pio_fifo #(.AW(AW), .DW(16)) u_h2d (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (host_wr),
        .din   (host_din),
        .pop   (h2d_pop),
        .dout  (h2d_dout),
        .count (h2d_count),
        .full  (h2d_full),
        .empty (h2d_empty)
    );

`ifdef JTDSP16_PIO_IRQ_EN
    // Raise irq when a host word lands in an empty h2d; acknowledge wins over a new set.
    always_ff @(posedge clk) begin
        if (rst || iack)
            irq <= 1'b0;
        else if (host_wr && h2d_empty && !flush)
            irq <= 1'b1;
    end
`else
    logic unused_iack;
    assign unused_iack = iack;
    assign irq         = 1'b0;
`endif
endmodule

// File: tb/tb_jtdsp16_pio_host.sv
// Bench for jtdsp16_pio_host (AW=2): directed DSP/host traffic, scoreboard queues checked by a monitor.
module tb_jtdsp16_pio_host;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pbus_out = '0;
    logic        pods_n = 1'b1;
    logic        pids_n = 1'b1;
    logic        psel = 1'b0;
    logic [15:0] pbus_in;
    logic        irq;
    logic        iack = 1'b0;
    logic [15:0] host_din = '0;
    logic        host_wr = 1'b0;
    logic        host_full;
    logic [15:0] host_dout;
    logic        host_rd = 1'b0;
    logic        host_empty;

`ifdef JTDSP16_PIO_IRQ_EN
    localparam logic [15:0] IRQ_ON = 16'd1;
`else
    localparam logic [15:0] IRQ_ON = 16'd0;
`endif

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_host[$];
    logic [15:0] exp_dsp[$];

    jtdsp16_pio_host #(.AW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .pbus_out   (pbus_out),
        .pods_n     (pods_n),
        .pids_n     (pids_n),
        .psel       (psel),
        .pbus_in    (pbus_in),
        .irq        (irq),
        .iack       (iack),
        .host_din   (host_din),
        .host_wr    (host_wr),
        .host_full  (host_full),
        .host_dout  (host_dout),
        .host_rd    (host_rd),
        .host_empty (host_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dsp_write(input logic sel, input logic [15:0] d);
        psel = sel; pbus_out = d; pods_n = 1'b0;
        tick();
        pods_n = 1'b1;
        tick();
    endtask

    task automatic dsp_read(input logic sel, input logic [15:0] e);
        exp_dsp.push_back(e);
        psel = sel; pids_n = 1'b0;
        tick();
        pids_n = 1'b1;
        tick();
    endtask

    task automatic host_write(input logic [15:0] d);
        host_din = d; host_wr = 1'b1;
        tick();
        host_wr = 1'b0;
    endtask

    task automatic host_read(input logic [15:0] e);
        exp_host.push_back(e);
        host_rd = 1'b1;
        tick();
        host_rd = 1'b0;
    endtask

    task automatic pulse_iack();
        iack = 1'b1;
        tick();
        iack = 1'b0;
    endtask

    // Monitor: compares DUT outputs against the scoreboard whenever a read is presented.
    logic mon_last_pids = 1'b1;
    always @(negedge clk) begin
        if (host_rd) begin
            if (exp_host.size() == 0) chk("host_rd_unexpected", host_dout, 16'hxxxx);
            else chk("host_dout", host_dout, exp_host.pop_front());
        end
        if (!pids_n && mon_last_pids) begin
            if (exp_dsp.size() == 0) chk("dsp_rd_unexpected", pbus_in, 16'hxxxx);
            else chk("pbus_in_read", pbus_in, exp_dsp.pop_front());
        end
        mon_last_pids = pids_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_pbus_in", pbus_in, 16'h0000);
        chk("rst_irq", {15'd0, irq}, 16'd0);
        chk("rst_host_full", {15'd0, host_full}, 16'd0);
        chk("rst_host_empty", {15'd0, host_empty}, 16'd1);
        chk("rst_host_dout", host_dout, 16'h0000);
        dsp_read(1'b1, 16'h0000);

        // DSP -> host, order preserved
        dsp_write(1'b0, 16'hbeef);
        dsp_write(1'b0, 16'hbef0);
        dsp_write(1'b0, 16'hbef1);
        chk("d2h_not_empty", {15'd0, host_empty}, 16'd0);
        host_read(16'hbeef);
        host_read(16'hbef0);
        host_read(16'hbef1);
        chk("d2h_empty_after", {15'd0, host_empty}, 16'd1);

        // Host -> DSP with interrupt
        host_write(16'hcafe);
        chk("irq_set", {15'd0, irq}, IRQ_ON);
        chk("h2d_visible", pbus_in, 16'hcafe);
        pulse_iack();
        chk("irq_cleared", {15'd0, irq}, 16'd0);
        dsp_read(1'b0, 16'hcafe);
        dsp_read(1'b1, 16'h0000);

        // d2h overflow (depth 4)
        for (int i = 1; i <= 5; i++) dsp_write(1'b0, 16'(i));
        dsp_read(1'b1, 16'h8080);
        dsp_write(1'b1, 16'h0002);
        dsp_read(1'b1, 16'h0080);
        for (int i = 1; i <= 4; i++) host_read(16'(i));
        chk("ovf_drain_empty", {15'd0, host_empty}, 16'd1);

        // h2d underflow
        dsp_read(1'b0, 16'h0000);
        dsp_read(1'b1, 16'h4000);
        dsp_write(1'b1, 16'h0002);
        dsp_read(1'b1, 16'h0000);

        // irq only on empty -> non-empty
        host_write(16'h00a1);
        chk("irq_set2", {15'd0, irq}, IRQ_ON);
        pulse_iack();
        host_write(16'h00a2);
        chk("irq_stays_low", {15'd0, irq}, 16'd0);

        // Simultaneous DSP pop and host push with 2 queued
        exp_dsp.push_back(16'h00a1);
        psel = 1'b0; pids_n = 1'b0;
        tick();
        pids_n = 1'b1; host_din = 16'h00a3; host_wr = 1'b1;
        tick();
        host_wr = 1'b0;
        dsp_read(1'b1, 16'h0002);
        dsp_read(1'b0, 16'h00a2);
        dsp_read(1'b0, 16'h00a3);
        dsp_read(1'b1, 16'h0000);

        // Flush via control word
        host_write(16'h00b1);
        host_write(16'h00b2);
        dsp_write(1'b0, 16'h00d1);
        dsp_read(1'b1, 16'h0022);
        dsp_write(1'b1, 16'h0001);
        dsp_read(1'b1, 16'h0000);
        chk("flush_host_empty", {15'd0, host_empty}, 16'd1);
        psel = 1'b0;
        #1;
        chk("flush_pbus_in", pbus_in, 16'h0000);

        // h2d full, extra host write ignored
        for (int i = 0; i < 4; i++) host_write(16'h00c0 + 16'(i));
        chk("h2d_full", {15'd0, host_full}, 16'd1);
        host_write(16'h00c4);
        dsp_read(1'b1, 16'h0004);
        for (int i = 0; i < 4; i++) dsp_read(1'b0, 16'h00c0 + 16'(i));
        chk("h2d_not_full", {15'd0, host_full}, 16'd0);
        dsp_read(1'b1, 16'h0000);

        // Reset mid-operation with pods_n held low
        host_write(16'h00e0);
        dsp_write(1'b0, 16'h00e1);
        psel = 1'b0; pbus_out = 16'hdead; pods_n = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0; pods_n = 1'b1;
        tick();
        tick();
        chk("rst2_host_empty", {15'd0, host_empty}, 16'd1);
        chk("rst2_host_dout", host_dout, 16'h0000);
        chk("rst2_pbus_in", pbus_in, 16'h0000);
        chk("rst2_irq", {15'd0, irq}, 16'd0);
        chk("rst2_host_full", {15'd0, host_full}, 16'd0);
        dsp_read(1'b1, 16'h0000);

        repeat (3) tick();
        chk("sb_host_drained", 16'(exp_host.size()), 16'd0);
        chk("sb_dsp_drained", 16'(exp_dsp.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
